// File: rtl/ram_arbiter.sv
// Two-requester arbiter (CPU, debug/loader) for a single-port synchronous RAM.
// Owner-sticky priority with a burst cap; read data is steered back to the winner.
module ram_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data
);

    localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    owner_t             r_owner;
    owner_t             r_rd_tag;
    logic [CNT_W-1:0]   r_burst;
    logic               r_rd_pend;

    owner_t             w_owner_nxt;
    owner_t             w_rd_tag_nxt;
    logic [CNT_W-1:0]   w_burst_nxt;
    logic               w_rd_pend_nxt;

    logic               w_cpu_win;
    logic               w_dbg_win;
    logic               w_win_we;
    owner_t             w_winner;

    // Arbitration: a lone requester always wins; on contention the owner keeps
    // the RAM until it has used up its burst allowance.
    always_comb begin
        w_cpu_win = 1'b0;
        w_dbg_win = 1'b0;
        if (rst_n) begin
            if (cpu_req && dbg_req) begin
                if (r_burst < BURST_MAX) begin
                    w_cpu_win = (r_owner == OWN_CPU);
                end else begin
                    w_cpu_win = (r_owner == OWN_DBG);
                end
                w_dbg_win = !w_cpu_win;
            end else begin
                w_cpu_win = cpu_req;
                w_dbg_win = dbg_req;
            end
        end
    end

    assign w_winner = w_dbg_win ? OWN_DBG : OWN_CPU;
    assign w_win_we = w_dbg_win ? dbg_we : cpu_we;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner   <= OWN_DBG;
            r_burst   <= BURST_MAX;
            r_rd_pend <= 1'b0;
            r_rd_tag  <= OWN_CPU;
        end else begin
            r_owner   <= w_owner_nxt;
            r_burst   <= w_burst_nxt;
            r_rd_pend <= w_rd_pend_nxt;
            r_rd_tag  <= w_rd_tag_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_owner_nxt   = r_owner;
        w_burst_nxt   = r_burst;
        w_rd_pend_nxt = 1'b0;
        w_rd_tag_nxt  = r_rd_tag;
        if (w_cpu_win || w_dbg_win) begin
            if (w_winner == r_owner) begin
                w_burst_nxt = (r_burst < BURST_MAX) ? r_burst + BURST_ONE : r_burst;
            end else begin
                w_owner_nxt = w_winner;
                w_burst_nxt = BURST_ONE;
            end
            w_rd_pend_nxt = !w_win_we;
            w_rd_tag_nxt  = w_winner;
        end
    end

    // Outputs: RAM bus is zeroed when idle; rvalid is masked during reset so a
    // read accepted just before reset never returns.
    always_comb begin
        cpu_gnt    = w_cpu_win;
        dbg_gnt    = w_dbg_win;
        ram_w_en   = 1'b0;
        ram_addr   = '0;
        ram_w_data = '0;
        if (w_cpu_win) begin
            ram_w_en   = cpu_we;
            ram_addr   = cpu_addr;
            ram_w_data = cpu_wdata;
        end else if (w_dbg_win) begin
            ram_w_en   = dbg_we;
            ram_addr   = dbg_addr;
            ram_w_data = dbg_wdata;
        end
        cpu_rvalid = rst_n && r_rd_pend && (r_rd_tag == OWN_CPU);
        dbg_rvalid = rst_n && r_rd_pend && (r_rd_tag == OWN_DBG);
        cpu_rdata  = cpu_rvalid ? ram_r_data : '0;
        dbg_rdata  = dbg_rvalid ? ram_r_data : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a behavioural 256x16 RAM behind the default
// instance, plus a MAX_BURST=1 instance for the alternation case.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;

    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0]  cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        ram_w_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_w_data;
    logic [15:0] ram_r_data;

    logic        b_cpu_req, b_dbg_req;
    logic        b_cpu_gnt, b_cpu_rvalid, b_dbg_gnt, b_dbg_rvalid;
    logic [15:0] b_cpu_rdata, b_dbg_rdata;
    logic        b_ram_w_en;
    logic [7:0]  b_ram_addr;
    logic [15:0] b_ram_w_data;
    logic [15:0] b_ram_r_data;

    logic [15:0] mem [256];

    int n_tests;
    int n_fail;

    ram_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
        .ram_r_data(ram_r_data)
    );

    ram_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(8'h05), .cpu_wdata(16'h0000),
        .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .dbg_req(b_dbg_req), .dbg_we(1'b0), .dbg_addr(8'h06), .dbg_wdata(16'h0000),
        .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata),
        .ram_w_en(b_ram_w_en), .ram_addr(b_ram_addr), .ram_w_data(b_ram_w_data),
        .ram_r_data(b_ram_r_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, 1-cycle synchronous read
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
        mem[8'h20] = 16'h1234;
        ram_r_data = 16'h0000;
    end

    always @(posedge clk) begin
        if (ram_w_en) mem[ram_addr] <= ram_w_data;
        ram_r_data <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000;
        b_cpu_req = 1'b0; b_dbg_req = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_cgnt"}, cpu_gnt, 1'b0);
        check({tag, "_dgnt"}, dbg_gnt, 1'b0);
        check({tag, "_crv"}, cpu_rvalid, 1'b0);
        check({tag, "_drv"}, dbg_rvalid, 1'b0);
        check({tag, "_wen"}, ram_w_en, 1'b0);
        check({tag, "_addr"}, ram_addr, 8'h00);
    endtask

    initial begin
        logic exp_c [10];
        n_tests = 0;
        n_fail  = 0;
        exp_c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // 1: reset then idle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_quiet("idle");
            next_cycle();
        end

        // 2: CPU writes 0xBEEF to 0x10, then reads it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        check("wr_cgnt", cpu_gnt, 1'b1);
        check("wr_dgnt", dbg_gnt, 1'b0);
        check("wr_wen", ram_w_en, 1'b1);
        check("wr_addr", ram_addr, 8'h10);
        check("wr_wdata", ram_w_data, 16'hBEEF);
        next_cycle();
        cpu_we = 1'b0; cpu_wdata = 16'h0000;
        @(negedge clk);
        check("rd_cgnt", cpu_gnt, 1'b1);
        check("rd_wen", ram_w_en, 1'b0);
        check("rd_addr", ram_addr, 8'h10);
        check("wr_no_rv", cpu_rvalid, 1'b0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_crv", cpu_rvalid, 1'b1);
        check("rd_cdata", cpu_rdata, 16'hBEEF);
        check("rd_drv", dbg_rvalid, 1'b0);
        check("rd_ddata", dbg_rdata, 16'h0000);
        check("rd_idle_wdata", ram_w_data, 16'h0000);

        // 3: both request from reset, burst cap 4
        do_reset();
        cpu_req = 1'b1; cpu_addr = 8'h01;
        dbg_req = 1'b1; dbg_addr = 8'h02;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("c3_cgnt%0d", i), cpu_gnt, exp_c[i]);
            check($sformatf("c3_dgnt%0d", i), dbg_gnt, !exp_c[i]);
            check($sformatf("c3_addr%0d", i), ram_addr, exp_c[i] ? 8'h01 : 8'h02);
            if (i == 0) begin
                check("c3_crv0", cpu_rvalid, 1'b0);
                check("c3_drv0", dbg_rvalid, 1'b0);
            end else begin
                check($sformatf("c3_crv%0d", i), cpu_rvalid, exp_c[i-1]);
                check($sformatf("c3_drv%0d", i), dbg_rvalid, !exp_c[i-1]);
                check($sformatf("c3_cdat%0d", i), cpu_rdata, exp_c[i-1] ? 16'h1111 : 16'h0000);
                check($sformatf("c3_ddat%0d", i), dbg_rdata, exp_c[i-1] ? 16'h0000 : 16'h2222);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        check("c3_tail_crv", cpu_rvalid, 1'b1);
        check("c3_tail_cdat", cpu_rdata, 16'h1111);
        next_cycle();
        @(negedge clk);
        check("c3_pulse_end", cpu_rvalid, 1'b0);

        // 4: six uncontested CPU grants saturate the burst count
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 8'h03;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("c4_solo%0d", i), cpu_gnt, 1'b1);
            next_cycle();
        end
        dbg_req = 1'b1; dbg_addr = 8'h04;
        @(negedge clk);
        check("c4_dgnt", dbg_gnt, 1'b1);
        check("c4_cgnt", cpu_gnt, 1'b0);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();

        // 5: read accepted just before reset is dropped
        dbg_req = 1'b1; dbg_addr = 8'h20;
        @(negedge clk);
        check("c5_dgnt", dbg_gnt, 1'b1);
        check("c5_addr", ram_addr, 8'h20);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check("c5_rst_drv", dbg_rvalid, 1'b0);
        check("c5_rst_ddat", dbg_rdata, 16'h0000);
        check("c5_rst_dgnt", dbg_gnt, 1'b0);
        check("c5_rst_addr", ram_addr, 8'h00);
        next_cycle();
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_addr = 8'h01;
        @(negedge clk);
        check("c5_post_drv", dbg_rvalid, 1'b0);
        check("c5_post_ddat", dbg_rdata, 16'h0000);
        check("c5_tie_cgnt", cpu_gnt, 1'b1);
        check("c5_tie_dgnt", dbg_gnt, 1'b0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // 6: MAX_BURST=1 alternates strictly
        b_cpu_req = 1'b1; b_dbg_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("c6_cgnt%0d", i), b_cpu_gnt, (i % 2) == 0);
            check($sformatf("c6_dgnt%0d", i), b_dbg_gnt, (i % 2) == 1);
            check($sformatf("c6_excl%0d", i), b_cpu_gnt & b_dbg_gnt, 1'b0);
            next_cycle();
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    assign b_ram_r_data = 16'h0000;

endmodule
